fma_dot_sequencer: RTL and testbench
====================================

Name: fma_dot_sequencer

Overview:
Command-driven initiator for one fused multiply-add accumulator lane in the matrix processor. It accepts a dot-product command (length, seed, strided base addresses for two operand memories) and issues synchronous reads. It streams the returned operands into the FMA with the correct en/updateAccumulator sequencing, then returns the final accumulator value on a valid/ready result port. One command is in flight at a time.

Parameters:
WIDTH, 32, operand/accumulator/result width
ADDR_W, 10, operand memory address width
LEN_W, 8, vector-length field width (max length 2^LEN_W-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE with rst low
cmd_len  in  LEN_W  element count N
cmd_seed  in  WIDTH  initial accumulator value
cmd_a_base / cmd_b_base  in  ADDR_W  first element address, A/B memory
cmd_a_stride / cmd_b_stride  in  ADDR_W  address increment per element
a_rd_en / b_rd_en  out  1  read strobe
a_rd_addr / b_rd_addr  out  ADDR_W  read address
a_rd_data / b_rd_data  in  WIDTH  read data, valid 1 cycle after strobe
fma_a / fma_b  out  WIDTH  FMA operands
fma_seed  out  WIDTH  latched cmd_seed
fma_update_acc  out  1  load seed instead of accumulator
fma_en  out  1  FMA accumulate enable
fma_acc  in  WIDTH  FMA accumulator output (registered in FMA)
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_data  out  WIDTH  dot-product result

Behaviour:
- Reset: state IDLE. All registered outputs are 0 (a/b_rd_en, addrs, fma_en, fma_update_acc, fma_seed, res_valid, res_data). cmd_ready is 0 while rst is high.
- fma_a = fma_en ? a_rd_data : 0. fma_b is formed the same way from b_rd_data. These are combinational.
- States:
  - IDLE: on cmd_valid&&cmd_ready, latch the command fields.
    - N==0: go to RESULT with res_data=cmd_seed.
    - Otherwise: go to ISSUE with counter=0.
  - ISSUE: each cycle, assert a_rd_en=b_rd_en=1 with addr = base + k*stride. Arithmetic is mod 2^ADDR_W, so addresses wrap silently. Increment k. After k==N-1 is issued, go to DRAIN.
  - Read pipeline: fma_en is a 1-cycle delayed copy of rd_en. fma_update_acc=1 only in the cycle fma_en carries element 0; otherwise 0.
  - DRAIN: the last fma_en cycle. Next state is CAPTURE.
  - CAPTURE: fma_en is low and fma_acc holds the final sum. Latch res_data<=fma_acc, then go to RESULT.
  - RESULT: res_valid=1 and res_data is held stable. On res_ready, go to IDLE. cmd_ready rises the following cycle.
- Latency: with the accept edge as cycle 0, reads are issued in cycles 1..N and fma_en is high in cycles 2..N+1. res_valid first asserts in cycle N+3. For N==0, res_valid asserts in cycle 1.
- Arithmetic: the sequencer performs no arithmetic on data. Sum truncation to WIDTH is owned by the FMA. res_data equals (seed + sum a_i*b_i) mod 2^WIDTH.
- No overlap: cmd_valid is ignored outside IDLE. Commands are never queued.
- Backpressure: res_valid and res_data are held indefinitely while res_ready is low. No FMA or memory activity occurs in RESULT.
- Reset mid-operation: abandon the command immediately. The next cycle shows reset values and no res_valid for the aborted command. The FMA sees no further fma_en.
- res_ready asserted outside RESULT has no effect.

Decomposition:
- Package matproc_pkg holds the state enum {IDLE, ISSUE, DRAIN, CAPTURE, RESULT} and the default WIDTH/ADDR_W/LEN_W localparams shared with the FMA lane.
- One sub-module, dot_addr_gen, is natural: a strided address counter with load(base, stride), step, and addr output. It is instantiated twice, once for A and once for B.

Test Plan:
1. N=3, seed=10, A=[1,2,3], B=[4,5,6], strides 1, with a behavioural FMA model. Expect res_data=42 with res_valid first high in cycle 6. Expect fma_update_acc high only in cycle 2.
2. N=0, seed=0xDEADBEEF. Expect res_valid in cycle 1 with res_data=0xDEADBEEF, and rd_en and fma_en never asserted.
3. ADDR_W=8, a_base=0xFE, stride 1, b_base=0x10, stride 3, N=4. Expect A addresses FE,FF,00,01 and B addresses 10,13,16,19 in consecutive cycles.
4. res_ready held low for 5 cycles. Expect res_valid/res_data stable, cmd_ready=0, and a concurrent cmd_valid ignored. After the handshake, expect cmd_ready=1 on the next cycle.
5. N=2, a=b=0xFFFFFFFF, seed 0. Expect res_data=0x00000002 (wrap).
6. Assert rst in cycle 3 of an N=8 command. Expect all outputs at 0 next cycle and no res_valid. A following N=1 command (2*3, seed 1) returns 7.

Source files
------------

// File: rtl/matproc_pkg.sv
// Shared types and default sizing for the matrix-processor FMA lane.
package matproc_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 32;
  localparam int unsigned DEFAULT_ADDR_W = 10;
  localparam int unsigned DEFAULT_LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CAPTURE,
    RESULT
  } seq_state_t;

endpackage

// File: rtl/dot_addr_gen.sv
// Strided address counter: load(base, stride) then step adds stride each cycle.
// Address arithmetic wraps modulo 2^ADDR_W.
module dot_addr_gen
  import matproc_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] stride_q;

  // Address register: load wins over step; stride kept for the whole command.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      stride_q <= '0;
    end else if (load) begin
      addr     <= base;
      stride_q <= stride;
    end else if (step) begin
      addr <= addr + stride_q;
    end
  end

endmodule

// File: rtl/fma_dot_sequencer.sv
// Dot-product command sequencer for one FMA accumulator lane: issues strided
// operand reads, streams returned data into the FMA, returns the final sum.
module fma_dot_sequencer
  import matproc_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned LEN_W  = DEFAULT_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [WIDTH-1:0]  cmd_seed,
  input  logic [ADDR_W-1:0] cmd_a_base,
  input  logic [ADDR_W-1:0] cmd_b_base,
  input  logic [ADDR_W-1:0] cmd_a_stride,
  input  logic [ADDR_W-1:0] cmd_b_stride,
  output logic              a_rd_en,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic [ADDR_W-1:0] b_rd_addr,
  input  logic [WIDTH-1:0]  a_rd_data,
  input  logic [WIDTH-1:0]  b_rd_data,
  output logic [WIDTH-1:0]  fma_a,
  output logic [WIDTH-1:0]  fma_b,
  output logic [WIDTH-1:0]  fma_seed,
  output logic              fma_update_acc,
  output logic              fma_en,
  input  logic [WIDTH-1:0]  fma_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data
);

  seq_state_t       state;
  logic [LEN_W-1:0] len_q;
  // Number of elements whose read has been issued, including the current one.
  logic [LEN_W-1:0] issued;
  logic             accept;
  logic             addr_load;
  logic             addr_step;

  // Command handshake; never ready while reset is held.
  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // Address generators load on accept of a non-empty command and step until
  // the last element has been issued.
  assign addr_load = accept && (cmd_len != '0);
  assign addr_step = (state == ISSUE) && (issued != len_q);

  // Operands are gated to zero whenever the FMA is not enabled.
  assign fma_a = fma_en ? a_rd_data : '0;
  assign fma_b = fma_en ? b_rd_data : '0;

  dot_addr_gen #(.ADDR_W(ADDR_W)) u_a_addr (
    .clk    (clk),
    .rst    (rst),
    .load   (addr_load),
    .step   (addr_step),
    .base   (cmd_a_base),
    .stride (cmd_a_stride),
    .addr   (a_rd_addr)
  );

  dot_addr_gen #(.ADDR_W(ADDR_W)) u_b_addr (
    .clk    (clk),
    .rst    (rst),
    .load   (addr_load),
    .step   (addr_step),
    .base   (cmd_b_base),
    .stride (cmd_b_stride),
    .addr   (b_rd_addr)
  );

  // Sequencer FSM with registered read strobes, FMA controls and result port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      len_q          <= '0;
      issued         <= '0;
      a_rd_en        <= 1'b0;
      b_rd_en        <= 1'b0;
      fma_en         <= 1'b0;
      fma_update_acc <= 1'b0;
      fma_seed       <= '0;
      res_valid      <= 1'b0;
      res_data       <= '0;
    end else begin
      // Read data returns one cycle after the strobe, so the FMA enable trails it.
      fma_en         <= a_rd_en;
      // Element 0 is being read while issued==1; the FMA sees it next cycle.
      fma_update_acc <= (state == ISSUE) && (issued == LEN_W'(1));

      unique case (state)
        IDLE: begin
          if (accept) begin
            len_q    <= cmd_len;
            fma_seed <= cmd_seed;
            if (cmd_len == '0) begin
              res_data  <= cmd_seed;
              res_valid <= 1'b1;
              state     <= RESULT;
            end else begin
              issued  <= LEN_W'(1);
              a_rd_en <= 1'b1;
              b_rd_en <= 1'b1;
              state   <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (issued == len_q) begin
            a_rd_en <= 1'b0;
            b_rd_en <= 1'b0;
            state   <= DRAIN;
          end else begin
            issued <= issued + LEN_W'(1);
          end
        end

        DRAIN: begin
          state <= CAPTURE;
        end

        CAPTURE: begin
          res_data  <= fma_acc;
          res_valid <= 1'b1;
          state     <= RESULT;
        end

        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Self-checking bench for fma_dot_sequencer with behavioural memories and FMA.
module tb_fma_dot_sequencer;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [WIDTH-1:0]  cmd_seed;
  logic [ADDR_W-1:0] cmd_a_base, cmd_b_base, cmd_a_stride, cmd_b_stride;
  logic              a_rd_en, b_rd_en;
  logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
  logic [WIDTH-1:0]  a_rd_data, b_rd_data;
  logic [WIDTH-1:0]  fma_a, fma_b, fma_seed, fma_acc;
  logic              fma_update_acc, fma_en;
  logic              res_valid, res_ready;
  logic [WIDTH-1:0]  res_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [WIDTH-1:0] acc;

  always #5 clk = ~clk;

  fma_dot_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_len        (cmd_len),
    .cmd_seed       (cmd_seed),
    .cmd_a_base     (cmd_a_base),
    .cmd_b_base     (cmd_b_base),
    .cmd_a_stride   (cmd_a_stride),
    .cmd_b_stride   (cmd_b_stride),
    .a_rd_en        (a_rd_en),
    .b_rd_en        (b_rd_en),
    .a_rd_addr      (a_rd_addr),
    .b_rd_addr      (b_rd_addr),
    .a_rd_data      (a_rd_data),
    .b_rd_data      (b_rd_data),
    .fma_a          (fma_a),
    .fma_b          (fma_b),
    .fma_seed       (fma_seed),
    .fma_update_acc (fma_update_acc),
    .fma_en         (fma_en),
    .fma_acc        (fma_acc),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data)
  );

  // Synchronous-read operand memories
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
    if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
  end

  // Behavioural FMA lane: registered accumulator, seed load on update_acc
  always @(posedge clk) begin
    if (rst) acc <= '0;
    else if (fma_en) acc <= (fma_update_acc ? fma_seed : acc) + fma_a * fma_b;
  end
  assign fma_acc = acc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int addr_of(input int base, input int stride, input int k);
    return (base + k * stride) % DEPTH;
  endfunction

  // Reference: seed plus sum of products over the strided element addresses
  function automatic logic [WIDTH-1:0] ref_dot(input int n, input logic [WIDTH-1:0] seed,
                                               input int ab, input int as, input int bb, input int bs);
    logic [WIDTH-1:0] s;
    s = seed;
    for (int k = 0; k < n; k++) s = s + mem_a[addr_of(ab, as, k)] * mem_b[addr_of(bb, bs, k)];
    return s;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    check_eq({pfx, "_a_rd_en"}, 64'(a_rd_en), 64'd0);
    check_eq({pfx, "_b_rd_en"}, 64'(b_rd_en), 64'd0);
    check_eq({pfx, "_a_rd_addr"}, 64'(a_rd_addr), 64'd0);
    check_eq({pfx, "_b_rd_addr"}, 64'(b_rd_addr), 64'd0);
    check_eq({pfx, "_fma_en"}, 64'(fma_en), 64'd0);
    check_eq({pfx, "_fma_upd"}, 64'(fma_update_acc), 64'd0);
    check_eq({pfx, "_fma_seed"}, 64'(fma_seed), 64'd0);
    check_eq({pfx, "_fma_a"}, 64'(fma_a), 64'd0);
    check_eq({pfx, "_res_valid"}, 64'(res_valid), 64'd0);
    check_eq({pfx, "_res_data"}, 64'(res_data), 64'd0);
  endtask

  // Run one command; per-cycle checks of read/FMA sequencing, latency, result, hold
  task automatic run_cmd(input int n, input logic [WIDTH-1:0] seed,
                         input int ab, input int as, input int bb, input int bs,
                         input int hold, output logic [WIDTH-1:0] got_res);
    logic [WIDTH-1:0] exp_res;
    int               first_valid;
    logic             exp_rd, exp_fe;
    exp_res = ref_dot(n, seed, ab, as, bb, bs);
    got_res = 'x;
    @(negedge clk);
    check_eq("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid    = 1'b1;
    cmd_len      = LEN_W'(n);
    cmd_seed     = seed;
    cmd_a_base   = ADDR_W'(ab);
    cmd_a_stride = ADDR_W'(as);
    cmd_b_base   = ADDR_W'(bb);
    cmd_b_stride = ADDR_W'(bs);
    @(posedge clk);
    first_valid = -1;
    for (int c = 1; c <= n + 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid    = 1'b0;
        cmd_seed     = $urandom;
        cmd_a_base   = ADDR_W'($urandom);
        cmd_b_stride = ADDR_W'($urandom);
        check_eq("fma_seed_latched", 64'(fma_seed), 64'(seed));
      end
      exp_rd = (c <= n);
      exp_fe = (c >= 2) && (c <= n + 1);
      check_eq("a_rd_en", 64'(a_rd_en), 64'(exp_rd));
      check_eq("b_rd_en", 64'(b_rd_en), 64'(exp_rd));
      if (exp_rd) begin
        check_eq("a_rd_addr", 64'(a_rd_addr), 64'(addr_of(ab, as, c - 1)));
        check_eq("b_rd_addr", 64'(b_rd_addr), 64'(addr_of(bb, bs, c - 1)));
      end
      check_eq("fma_en", 64'(fma_en), 64'(exp_fe));
      check_eq("fma_update_acc", 64'(fma_update_acc), 64'(n > 0 && c == 2));
      check_eq("fma_a", 64'(fma_a), exp_fe ? 64'(mem_a[addr_of(ab, as, c - 2)]) : 64'd0);
      check_eq("fma_b", 64'(fma_b), exp_fe ? 64'(mem_b[addr_of(bb, bs, c - 2)]) : 64'd0);
      check_eq("busy_cmd_ready", 64'(cmd_ready), 64'd0);
      if (res_valid) begin
        first_valid = c;
        break;
      end
    end
    check_eq("res_latency", 64'(first_valid), 64'((n == 0) ? 1 : n + 3));
    check_eq("res_data", 64'(res_data), 64'(exp_res));
    got_res = res_data;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'($urandom_range(1, 5));
      @(negedge clk);
      check_eq("hold_res_valid", 64'(res_valid), 64'd1);
      check_eq("hold_res_data", 64'(res_data), 64'(exp_res));
      check_eq("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      check_eq("hold_rd_en", 64'(a_rd_en | b_rd_en), 64'd0);
      check_eq("hold_fma_en", 64'(fma_en), 64'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("post_res_valid", 64'(res_valid), 64'd0);
    check_eq("post_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] got;
    int n, ab, as, bb, bs;
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_len      = '0;
    cmd_seed     = '0;
    cmd_a_base   = '0;
    cmd_b_base   = '0;
    cmd_a_stride = '0;
    cmd_b_stride = '0;
    res_ready    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Small known dot product
    mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3;
    mem_b[0] = 4; mem_b[1] = 5; mem_b[2] = 6;
    run_cmd(3, 32'd10, 0, 1, 0, 1, 0, got);
    check_eq("t1_res42", 64'(got), 64'd42);

    // Empty command returns the seed
    run_cmd(0, 32'hDEADBEEF, 5, 1, 7, 1, 0, got);
    check_eq("t2_seed", 64'(got), 64'hDEADBEEF);

    // Address wrap and distinct strides
    run_cmd(4, $urandom, 'hFE, 1, 'h10, 3, 1, got);

    // Backpressure with a concurrent command offered
    run_cmd(2, $urandom, 3, 2, 9, 1, 5, got);

    // Product and sum wrap
    mem_a[8'h40] = 32'hFFFFFFFF; mem_a[8'h41] = 32'hFFFFFFFF;
    mem_b[8'h40] = 32'hFFFFFFFF; mem_b[8'h41] = 32'hFFFFFFFF;
    run_cmd(2, 32'd0, 'h40, 1, 'h40, 1, 0, got);
    check_eq("t5_wrap", 64'(got), 64'd2);

    // Reset during an N=8 command
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_len      = LEN_W'(8);
    cmd_seed     = 32'h1234;
    cmd_a_base   = '0;
    cmd_b_base   = '0;
    cmd_a_stride = ADDR_W'(1);
    cmd_b_stride = ADDR_W'(1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_abort_rd_en", 64'(a_rd_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("abort_no_valid", 64'(res_valid), 64'd0);
      check_eq("abort_no_fma_en", 64'(fma_en), 64'd0);
      check_eq("abort_no_rd_en", 64'(a_rd_en | b_rd_en), 64'd0);
    end
    mem_a[8'h20] = 32'd2;
    mem_b[8'h30] = 32'd3;
    run_cmd(1, 32'd1, 'h20, 1, 'h30, 1, 0, got);
    check_eq("t6_res7", 64'(got), 64'd7);

    // Randomized commands, including one maximum-length vector
    for (int i = 0; i < 25; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_a[j] = $urandom;
        mem_b[j] = $urandom;
      end
      n  = (i == 0) ? 255 : int'($urandom_range(0, 20));
      ab = int'($urandom_range(0, DEPTH - 1));
      as = int'($urandom_range(0, DEPTH - 1));
      bb = int'($urandom_range(0, DEPTH - 1));
      bs = int'($urandom_range(0, DEPTH - 1));
      run_cmd(n, $urandom, ab, as, bb, bs, int'($urandom_range(0, 3)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
